ov7670_sccb_config_seq: RTL and testbench



---
 rtl/ov7670_sccb_config_seq.sv | 202 ++++++++++++++++++++
 tb/tb_ov7670_sccb_config_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config_seq.sv
// Walks a register ROM and writes each entry to an OV7670 over SCCB (3-phase write); 140*QTR cycles per write plus 2 cycles of ROM fetch/decode.
// No backpressure: the ROM is read open-loop, the bus is write-only, and a start pulse is honoured only from IDLE or DONE.
module ov7670_sccb_config_seq #(
    parameter int         QTR        = 125,
    parameter int         BOOT_CYC   = 1000000,
    parameter int         DLY_CYC    = 1000000,
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         ROM_AW     = 8,
    parameter int         AUTO_START = 1
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sioc,
    output logic              siod_o,
    output logic              siod_t,
    output logic              busy,
    output logic              config_finished,
    output logic              err,
    output logic [ROM_AW:0]   wr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BOOT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_XFER   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DELAY  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [31:0]       QTR_LAST  = 32'(QTR - 1);
    localparam logic [31:0]       BOOT_LAST = 32'(BOOT_CYC - 1);
    localparam logic [31:0]       DLY_LAST  = 32'(DLY_CYC - 1);
    localparam logic [5:0]        LAST_SLOT = 6'd33;
    localparam logic [ROM_AW-1:0] ADDR_MAX  = '1;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [5:0]  slot;
    logic [1:0]  qtr;
    logic [26:0] shift_word;
    logic        auto_pend;
    logic        qtr_tick;
    logic [5:0]  nxt_slot;
    logic [1:0]  nxt_qtr;
    logic [1:0]  nxt_bus;

    assign siod_o   = 1'b0;
    assign qtr_tick = ((state == S_XFER) || (state == S_GAP)) && (cnt == QTR_LAST);

    // Slot map: 0 = START, 1..27 = word bits MSB-first, 28 = STOP, 29..33 = bus idle
    // so every write occupies the same fixed 34-slot window. Returns {sioc, siod_t}.
    function automatic logic [1:0] bus_level(input logic [5:0] s, input logic [1:0] q,
                                             input logic [26:0] w);
        logic b;
        b = w[5'(5'd27 - s[4:0])];
        if (s == 6'd0) begin
            case (q)
                2'd0:    bus_level = 2'b11;
                2'd3:    bus_level = 2'b00;
                default: bus_level = 2'b10;
            endcase
        end else if (s <= 6'd27) begin
            bus_level = {(q == 2'd1) || (q == 2'd2), b};
        end else if (s == 6'd28) begin
            case (q)
                2'd0:    bus_level = 2'b00;
                2'd1:    bus_level = 2'b10;
                default: bus_level = 2'b11;
            endcase
        end else begin
            bus_level = 2'b11;
        end
    endfunction

    always_comb begin
        nxt_qtr  = qtr + 2'd1;
        nxt_slot = (qtr == 2'd3) ? slot + 6'd1 : slot;
        nxt_bus  = bus_level(nxt_slot, nxt_qtr, shift_word);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state           <= S_IDLE;
            cnt             <= '0;
            slot            <= '0;
            qtr             <= '0;
            shift_word      <= '0;
            auto_pend       <= (AUTO_START != 0);
            rom_addr        <= '0;
            wr_count        <= '0;
            sioc            <= 1'b1;
            siod_t          <= 1'b1;
            busy            <= 1'b0;
            config_finished <= 1'b0;
            err             <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start || ((state == S_IDLE) && auto_pend)) begin
                        state           <= S_BOOT;
                        cnt             <= '0;
                        auto_pend       <= 1'b0;
                        rom_addr        <= '0;
                        wr_count        <= '0;
                        err             <= 1'b0;
                        config_finished <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                S_BOOT: begin
                    if (cnt == BOOT_LAST) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rom_data == 16'hFFFF) begin
                        state           <= S_DONE;
                        config_finished <= 1'b1;
                        busy            <= 1'b0;
                    end else if (rom_data == 16'hFFF0) begin
                        state <= S_DELAY;
                        cnt   <= '0;
                    end else begin
                        shift_word <= {DEV_ID, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                        state      <= S_XFER;
                        cnt        <= '0;
                        slot       <= '0;
                        qtr        <= '0;
                        sioc       <= 1'b1;
                        siod_t     <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (qtr_tick) begin
                        cnt <= '0;
                        if ((slot == LAST_SLOT) && (qtr == 2'd3)) begin
                            state  <= S_GAP;
                            slot   <= '0;
                            qtr    <= '0;
                            sioc   <= 1'b1;
                            siod_t <= 1'b1;
                        end else begin
                            slot   <= nxt_slot;
                            qtr    <= nxt_qtr;
                            sioc   <= nxt_bus[1];
                            siod_t <= nxt_bus[0];
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (qtr_tick) begin
                        cnt <= '0;
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd3) begin
                            wr_count <= wr_count + 1'b1;
                            // Running off the end of the ROM is an error; the address never wraps.
                            if (rom_addr == ADDR_MAX) begin
                                state           <= S_DONE;
                                err             <= 1'b1;
                                config_finished <= 1'b1;
                                busy            <= 1'b0;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DELAY: begin
                    if (cnt == DLY_LAST) begin
                        cnt <= '0;
                        if (rom_addr == ADDR_MAX) begin
                            state           <= S_DONE;
                            err             <= 1'b1;
                            config_finished <= 1'b1;
                            busy            <= 1'b0;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_config_seq.sv
// Bench for ov7670_sccb_config_seq: an SCCB bus monitor decodes bytes and checks them against a queue
// of expected bytes filled as ROM contents are loaded; scenario tasks check timing and status.
module tb_ov7670_sccb_config_seq;

    localparam int QTR      = 4;
    localparam int BOOT_CYC = 16;
    localparam int DLY_CYC  = 32;
    localparam int ROM_AW   = 4;

    logic        clk;
    logic        rst_n, start;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sioc, siod_o, siod_t, busy, cfg_done, err;
    logic [4:0]  wr_count;

    logic        rst_b, start_b;
    logic [3:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic        sioc_b, siod_o_b, siod_t_b, busy_b, cfg_done_b, err_b;
    logic [4:0]  wr_count_b;

    logic [15:0] rom   [16];
    logic [15:0] rom_b [16];

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         start_times[$];
    int         first_fall = -1;
    bit         mon_in_xfer = 0;
    int         mon_nbits = 0;
    int         rel;

    ov7670_sccb_config_seq #(
        .QTR(QTR), .BOOT_CYC(BOOT_CYC), .DLY_CYC(DLY_CYC), .DEV_ID(8'h42),
        .ROM_AW(ROM_AW), .AUTO_START(1)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .sioc(sioc), .siod_o(siod_o),
        .siod_t(siod_t), .busy(busy), .config_finished(cfg_done), .err(err),
        .wr_count(wr_count)
    );

    ov7670_sccb_config_seq #(
        .QTR(QTR), .BOOT_CYC(BOOT_CYC), .DLY_CYC(DLY_CYC), .DEV_ID(8'h42),
        .ROM_AW(ROM_AW), .AUTO_START(0)
    ) dut_b (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .sioc(sioc_b), .siod_o(siod_o_b),
        .siod_t(siod_t_b), .busy(busy_b), .config_finished(cfg_done_b), .err(err_b),
        .wr_count(wr_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rom_data   <= rom[rom_addr];
        rom_data_b <= rom_b[rom_addr_b];
    end

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic push_write(input logic [15:0] w);
        exp_q.push_back(8'h42);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic pulse_start(output int t);
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finished(input int budget, input string name, output int seen);
        int n = 0;
        while (cfg_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        seen = cyc;
        checks++;
        if (cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: config_finished=%b after %0d cycles, required 1", name, cfg_done, n);
        end
    endtask

    // Samples the main DUT's bus on the falling clock edge, away from output updates.
    task automatic bus_monitor();
        logic       ps, pd, cs, cd;
        logic [8:0] sh = '0;
        logic [7:0] eb;
        bit         ok;
        ps = sioc;
        pd = siod_t;
        forever begin
            @(negedge clk);
            cs = sioc;
            cd = siod_t;
            if (ps === 1'b1 && cs === 1'b0 && first_fall < 0) first_fall = cyc;
            if (cd !== pd) begin
                checks++;
                if (ps === 1'b1 && cs === 1'b1) begin
                    if (cd === 1'b0) begin
                        ok = !mon_in_xfer;
                        mon_in_xfer = 1'b1;
                        mon_nbits = 0;
                        start_times.push_back(cyc);
                    end else begin
                        ok = mon_in_xfer && (mon_nbits == 27);
                        mon_in_xfer = 1'b0;
                    end
                end else begin
                    ok = (ps === 1'b0) && (cs === 1'b0);
                end
                if (!ok) begin
                    failures++;
                    $display("FAIL bus_edge at cycle %0d: siod_t %b->%b with sioc %b->%b bits=%0d, required change only with sioc low or a legal START/STOP",
                             cyc, pd, cd, ps, cs, mon_nbits);
                end
            end
            if (mon_in_xfer && ps === 1'b0 && cs === 1'b1 && mon_nbits < 27) begin
                sh = {sh[7:0], cd};
                mon_nbits++;
                if (mon_nbits % 9 == 0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL bus_byte: got %h, required no further byte", sh[8:1]);
                    end else begin
                        eb = exp_q.pop_front();
                        if (sh[8:1] !== eb) begin
                            failures++;
                            $display("FAIL bus_byte: got %h, required %h", sh[8:1], eb);
                        end
                    end
                    checks++;
                    if (sh[0] !== 1'b1) begin
                        failures++;
                        $display("FAIL bus_ack: ack slot siod_t=%b, required 1", sh[0]);
                    end
                end
            end
            ps = cs;
            pd = cd;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rst_b = 1'b0; start_b = 1'b0;
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280;
        for (int i = 0; i < 16; i++) rom_b[i] = 16'hFFFF;
        rom_b[0] = 16'h1280;
        repeat (3) @(negedge clk);
        fork
            bus_monitor();
        join_none
        checks++;
        if ({sioc, siod_t, siod_o, busy, cfg_done, err} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_outputs: {sioc,siod_t,siod_o,busy,fin,err}=%b, required 110000",
                     {sioc, siod_t, siod_o, busy, cfg_done, err});
        end
        checks++;
        if (rom_addr !== 4'd0 || wr_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_counts: rom_addr=%0d wr_count=%0d, required 0 0", rom_addr, wr_count);
        end
        push_write(16'h1280);
        rst_n = 1'b1;
        rst_b = 1'b1;
        rel = cyc + 1;
    endtask

    task automatic test_single_write();
        int seen;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL auto_start_busy: busy=%b, required 1", busy);
        end
        checks++;
        if (busy_b !== 1'b0 || sioc_b !== 1'b1) begin
            failures++;
            $display("FAIL no_auto_start: busy=%b sioc=%b, required 0 1", busy_b, sioc_b);
        end
        wait_finished(2000, "single", seen);
        // START holds sioc high for three quarters, so the first fall follows BOOT, FETCH, DECODE and 3 quarters.
        checks++;
        if (first_fall - rel !== BOOT_CYC + 2 + 3 * QTR) begin
            failures++;
            $display("FAIL first_fall: %0d cycles after release, required %0d", first_fall - rel, BOOT_CYC + 2 + 3 * QTR);
        end
        checks++;
        if (wr_count !== 5'd1 || err !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd1) begin
            failures++;
            $display("FAIL single_status: wr_count=%0d err=%b busy=%b rom_addr=%0d, required 1 0 0 1", wr_count, err, busy, rom_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_bytes: %0d bytes not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_delay();
        int t, seen;
        fill_rom(16'hFFFF);
        rom[0] = 16'h1101; rom[1] = 16'hFFF0; rom[2] = 16'h3A04;
        push_write(16'h1101);
        push_write(16'h3A04);
        start_times.delete();
        pulse_start(t);
        wait_finished(3000, "delay", seen);
        checks++;
        if (wr_count !== 5'd2 || err !== 1'b0 || rom_addr !== 4'd3) begin
            failures++;
            $display("FAIL delay_status: wr_count=%0d err=%b rom_addr=%0d, required 2 0 3", wr_count, err, rom_addr);
        end
        checks++;
        if (start_times.size() != 2) begin
            failures++;
            $display("FAIL delay_starts: %0d START conditions, required 2", start_times.size());
        end else if (start_times[1] - start_times[0] != 140 * QTR + DLY_CYC + 4) begin
            failures++;
            $display("FAIL delay_spacing: %0d cycles between STARTs, required %0d",
                     start_times[1] - start_times[0], 140 * QTR + DLY_CYC + 4);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL delay_bytes: %0d bytes not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_restart_ignored();
        int t0, t1, seen, n;
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280;
        push_write(16'h1280);
        start_times.delete();
        pulse_start(t0);
        checks++;
        if (cfg_done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL replay_status: fin=%b busy=%b, required 0 1", cfg_done, busy);
        end
        n = 0;
        while (mon_nbits < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        pulse_start(t1);
        wait_finished(2000, "replay", seen);
        checks++;
        if (seen - (t0 + 1) != BOOT_CYC + 2 + 140 * QTR + 2) begin
            failures++;
            $display("FAIL replay_duration: %0d cycles, required %0d", seen - (t0 + 1), BOOT_CYC + 2 + 140 * QTR + 2);
        end
        checks++;
        if (start_times.size() != 1 || wr_count !== 5'd1) begin
            failures++;
            $display("FAIL replay_writes: starts=%0d wr_count=%0d, required 1 1", start_times.size(), wr_count);
        end
    endtask

    task automatic test_no_end_marker();
        int t, seen;
        fill_rom(16'h0102);
        for (int i = 0; i < 16; i++) push_write(16'h0102);
        pulse_start(t);
        wait_finished(12000, "no_end", seen);
        checks++;
        if (err !== 1'b1 || wr_count !== 5'd16 || rom_addr !== 4'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_end_status: err=%b wr_count=%0d rom_addr=%0d busy=%b, required 1 16 15 0", err, wr_count, rom_addr, busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rom_addr !== 4'd15 || cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL no_end_hold: rom_addr=%0d fin=%b, required 15 1", rom_addr, cfg_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL no_end_bytes: %0d bytes not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_xfer();
        int   n, rises, bad;
        logic ps;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0; rises = 0; ps = sioc_b;
        while (rises < 10 && n < 2000) begin
            @(negedge clk);
            if (ps === 1'b0 && sioc_b === 1'b1) rises++;
            ps = sioc_b;
            n++;
        end
        checks++;
        if (rises != 10 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach: rises=%0d busy=%b, required 10 1", rises, busy_b);
        end
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({sioc_b, siod_t_b, siod_o_b, busy_b, cfg_done_b, err_b} !== 6'b110000) begin
            failures++;
            $display("FAIL midreset_outputs: {sioc,siod_t,siod_o,busy,fin,err}=%b, required 110000",
                     {sioc_b, siod_t_b, siod_o_b, busy_b, cfg_done_b, err_b});
        end
        checks++;
        if (rom_addr_b !== 4'd0 || wr_count_b !== 5'd0) begin
            failures++;
            $display("FAIL midreset_counts: rom_addr=%0d wr_count=%0d, required 0 0", rom_addr_b, wr_count_b);
        end
        rst_b = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (sioc_b !== 1'b1 || siod_t_b !== 1'b1 || busy_b !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_quiet: %0d active cycles after reset, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_delay();
        test_restart_ignored();
        test_no_end_marker();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
